// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the AHB/SPI bridge: sequencer state encoding, SPI mode constants
// and default widths. The AHB slave decodes spi_state_t for its status register.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_PUSH  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_t;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic       SCLK_IDLE = SPI_MODE0[1];

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_CS_GAP     = 2;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: divides clk by 2*CLK_DIV while run is high and flags the cycle in which
// sclk is about to leave (rise_pulse) or return to (fall_pulse) its idle level.
module spi_clk_div
    import spi_bridge_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sclk,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int               DIV_W    = clog2_min1(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap       = run && (div_cnt == DIV_LAST);
    assign rise_pulse = wrap && (sclk == SCLK_IDLE);
    assign fall_pulse = wrap && (sclk != SCLK_IDLE);

    // Dropping run parks the divider so the next frame starts with a full half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sclk    <= SCLK_IDLE;
        end else if (!run) begin
            div_cnt <= '0;
            sclk    <= SCLK_IDLE;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master sequencer between the TX/RX byte FIFOs and the SPI pins:
// one TX byte popped, shifted out MSB first, and one RX byte pushed per cs_n window.
module spi_xfer_ctrl
    import spi_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CS_GAP     = DEF_CS_GAP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  tx_empty,
    output logic                  tx_rd_en,
    input  logic [DATA_WIDTH-1:0] tx_dout,
    input  logic                  rx_full,
    output logic                  rx_wr_en,
    output logic [DATA_WIDTH-1:0] rx_din,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n,
    output logic                  busy
);

    localparam int               BIT_W    = clog2_min1(DATA_WIDTH);
    localparam int               GAP_W    = clog2_min1(CS_GAP + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    spi_state_t            state;
    spi_state_t            state_next;
    logic [BIT_W-1:0]      bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] tx_next;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  run;
    logic                  rise_pulse;
    logic                  fall_pulse;
    logic                  last_bit;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .sclk      (sclk),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    // The final falling edge ends SHIFT instead of advancing, so bit_cnt never wraps.
    assign last_bit = fall_pulse && (bit_cnt == BIT_LAST);
    assign tx_next  = tx_sr << 1;
    assign rx_din   = rx_sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_rd_en   = 1'b0;
        rx_wr_en   = 1'b0;
        run        = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (enable && !tx_empty) begin
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                tx_rd_en   = 1'b1;
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                run = 1'b1;
                if (last_bit) begin
                    state_next = ST_PUSH;
                end
            end
            ST_PUSH: begin
                // Hold the frame (cs_n low) until the RX FIFO has room.
                if (!rx_full) begin
                    rx_wr_en   = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            rx_sr   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    cs_n    <= 1'b0;
                    mosi    <= tx_dout[DATA_WIDTH-1];
                    bit_cnt <= '0;
                end
                ST_SHIFT: begin
                    if (rise_pulse) begin
                        rx_sr <= (rx_sr << 1) | DATA_WIDTH'(miso);
                    end
                    if (fall_pulse && !last_bit) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        mosi    <= tx_next[DATA_WIDTH-1];
                    end
                end
                ST_PUSH: begin
                    if (!rx_full) begin
                        cs_n    <= 1'b1;
                        mosi    <= 1'b0;
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Data-only shift register; its content is meaningless until LOAD.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            tx_sr <= tx_dout;
        end else if (state == ST_SHIFT && fall_pulse && !last_bit) begin
            tx_sr <= tx_next;
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: queue-based TX/RX FIFO models, an SPI slave model and a
// frame-level monitor, driven by directed scenarios followed by a randomized phase.
module tb_spi_xfer_ctrl;

    localparam int DW        = 8;
    localparam int CD        = 4;
    localparam int CG        = 2;
    localparam int DEPTH     = 16;
    // POP cycle + LOAD cycle + DW bits of 2*CD cycles each, then rx_wr_en
    localparam int FRAME_LAT = 1 + 1 + 2 * CD * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          tx_empty = 1'b1;
    logic          tx_rd_en;
    logic [DW-1:0] tx_dout = '0;
    logic          rx_full = 1'b0;
    logic          rx_wr_en;
    logic [DW-1:0] rx_din;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          cs_n;
    logic          busy;

    logic          loop = 1'b1;
    logic          slave_miso = 1'b0;
    logic [DW-1:0] txq[$];
    logic [DW-1:0] rxq[$];

    int n_chk = 0;
    int n_fail = 0;

    // monitor state
    int            cyc = 0;
    int            rd_cyc = 0;
    int            last_wr = -1000;
    int            cs_rise = -1000;
    int            nrise = 0;
    int            nfall = 0;
    int            nrd = 0;
    int            ncs = 0;
    int            frames_done = 0;
    int            slave_idx = 0;
    logic          in_frame = 1'b0;
    logic          stalled = 1'b0;
    logic          p_sclk = 1'b0;
    logic          p_cs = 1'b1;
    logic          prev_en = 1'b0;
    logic [DW-1:0] exp_byte = '0;
    logic [DW-1:0] frame_slave = '0;
    logic [DW-1:0] mosi_cap = '0;
    logic [DW-1:0] last_rx = '0;

    assign miso = loop ? mosi : slave_miso;

    spi_xfer_ctrl #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (CD),
        .CS_GAP    (CG)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .tx_empty(tx_empty),
        .tx_rd_en(tx_rd_en),
        .tx_dout (tx_dout),
        .rx_full (rx_full),
        .rx_wr_en(rx_wr_en),
        .rx_din  (rx_din),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n),
        .busy    (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic void update_flags();
        tx_empty = (txq.size() == 0);
        rx_full  = (rxq.size() >= DEPTH);
    endfunction

    // FIFO models: strobes seen mid-cycle take effect just after the next rising edge.
    initial begin
        logic          rd;
        logic          wr;
        logic [DW-1:0] din;
        forever begin
            @(negedge clk);
            rd  = tx_rd_en;
            wr  = rx_wr_en;
            din = rx_din;
            @(posedge clk);
            #1;
            if (rd && txq.size() > 0) tx_dout = txq.pop_front();
            if (wr) rxq.push_back(din);
            update_flags();
        end
    end

    // Frame monitor and mode-0 slave (slave shifts its byte out on sclk falling edges).
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_cs_n", cs_n, 1'b1);
            chk("rst_sclk", sclk, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_wr", rx_wr_en, 1'b0);
            in_frame   = 1'b0;
            stalled    = 1'b0;
            nrise      = 0;
            nfall      = 0;
            cs_rise    = cyc;
            slave_miso = 1'b0;
        end else begin
            chk("strobe_excl", tx_rd_en & rx_wr_en, 1'b0);
            if (!busy) chk("idle_pins", {cs_n, sclk}, 2'b10);
            if (tx_rd_en) begin
                chk("rd_nonempty", tx_empty, 1'b0);
                chk("rd_enable", prev_en, 1'b1);
                chk("rd_single", in_frame, 1'b0);
                chk("gap_after_wr", (cyc - last_wr) >= CG + 1, 1'b1);
                if (txq.size() > 0) exp_byte = txq[0];
                in_frame = 1'b1;
                stalled  = 1'b0;
                rd_cyc   = cyc;
                nrise    = 0;
                nfall    = 0;
                mosi_cap = '0;
                nrd++;
            end
            if (p_cs && !cs_n) begin
                chk("cs_gap", (cyc - cs_rise) >= CG, 1'b1);
                ncs++;
                frame_slave = DW'($urandom);
                slave_idx   = 0;
                slave_miso  = frame_slave[DW-1];
            end
            if (!p_cs && cs_n) cs_rise = cyc;
            if (!p_sclk && sclk) begin
                chk("rise_cs_low", cs_n, 1'b0);
                chk("rise_in_frame", nrise < DW, 1'b1);
                if (nrise < DW) chk("mosi_bit", mosi, exp_byte[DW-1-nrise]);
                mosi_cap = {mosi_cap[DW-2:0], mosi};
                nrise++;
            end
            if (p_sclk && !sclk) begin
                nfall++;
                slave_idx++;
                if (slave_idx < DW) slave_miso = frame_slave[DW-1-slave_idx];
            end
            if (in_frame && nfall == DW && rx_full && !rx_wr_en) begin
                stalled = 1'b1;
                chk("stall_pins", {cs_n, sclk}, 2'b00);
            end
            if (rx_wr_en) begin
                chk("wr_in_frame", in_frame, 1'b1);
                chk("wr_data", rx_din, loop ? exp_byte : frame_slave);
                chk("wr_bits", nrise, DW);
                chk("wr_notfull", rx_full, 1'b0);
                chk("wr_pins", {cs_n, sclk}, 2'b00);
                if (!stalled) chk("latency", cyc - rd_cyc, FRAME_LAT);
                frames_done++;
                last_rx  = rx_din;
                last_wr  = cyc;
                in_frame = 1'b0;
            end
        end
        p_sclk  = sclk;
        p_cs    = cs_n;
        prev_en = enable;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic tx_push(input logic [DW-1:0] b);
        txq.push_back(b);
        update_flags();
    endtask

    task automatic rx_pop(output logic [DW-1:0] b);
        b = (rxq.size() > 0) ? rxq.pop_front() : '0;
        update_flags();
    endtask

    task automatic wait_frames(input int target, input int limit, input string tag);
        int i = 0;
        while (frames_done < target && i < limit) begin
            step();
            i++;
        end
        chk({tag, "_done"}, frames_done >= target, 1'b1);
    endtask

    task automatic wait_rises(input int n, input int limit, input string tag);
        int i = 0;
        while (!(in_frame && nrise >= n) && i < limit) begin
            step();
            i++;
        end
        chk({tag, "_rises"}, in_frame && nrise >= n, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] v;
        int f0;
        int n0;
        int pushed;
        int i;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_rd_en", tx_rd_en, 1'b0);
        chk("rst_rx_din", rx_din, '0);
        chk("rst_mosi", mosi, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // single frame, loopback
        loop = 1'b1;
        tx_push(8'hA5);
        enable = 1'b1;
        wait_frames(1, 200, "t1");
        chk("t1_mosi_seq", mosi_cap, 8'hA5);
        step();
        rx_pop(v);
        chk("t1_rx", v, 8'hA5);

        // three back-to-back frames
        n0 = ncs;
        tx_push(8'h3C);
        tx_push(8'hFF);
        tx_push(8'h00);
        wait_frames(4, 500, "t2");
        step();
        chk("t2_cs_windows", ncs - n0, 3);
        chk("t2_tx_left", txq.size(), 0);
        rx_pop(v); chk("t2_rx0", v, 8'h3C);
        rx_pop(v); chk("t2_rx1", v, 8'hFF);
        rx_pop(v); chk("t2_rx2", v, 8'h00);

        // RX full stall
        for (int k = 0; k < DEPTH; k++) rxq.push_back(8'hEE);
        update_flags();
        f0 = frames_done;
        tx_push(8'h81);
        i = 0;
        while (!(in_frame && nfall == DW) && i < 300) begin
            step();
            i++;
        end
        chk("t3_reach_push", in_frame && nfall == DW, 1'b1);
        steps(5);
        chk("t3_stall_wr", rx_wr_en, 1'b0);
        chk("t3_stall_cs", cs_n, 1'b0);
        chk("t3_stall_sclk", sclk, 1'b0);
        chk("t3_stall_busy", busy, 1'b1);
        chk("t3_stall_frames", frames_done, f0);
        rx_pop(v);
        @(negedge clk);
        chk("t3_release_wr", rx_wr_en, 1'b1);
        chk("t3_release_din", rx_din, 8'h81);
        step();
        for (int k = 0; k < DEPTH - 1; k++) rx_pop(v);
        rx_pop(v);
        chk("t3_rx", v, 8'h81);

        // enable dropped mid-frame
        f0 = frames_done;
        tx_push(8'h5A);
        tx_push(8'h11);
        wait_rises(3, 300, "t4");
        enable = 1'b0;
        wait_frames(f0 + 1, 200, "t4");
        chk("t4_last", last_rx, 8'h5A);
        n0 = nrd;
        steps(100);
        chk("t4_no_pop", nrd, n0);
        chk("t4_tx_kept", tx_empty, 1'b0);
        chk("t4_idle", busy, 1'b0);
        rx_pop(v);
        chk("t4_rx", v, 8'h5A);

        // reset in the middle of SHIFT (0x11 is discarded)
        tx_push(8'h22);
        enable = 1'b1;
        wait_rises(4, 300, "t5");
        f0 = frames_done;
        reset = 1'b1;
        #1;
        chk("t5_cs_n", cs_n, 1'b1);
        chk("t5_sclk", sclk, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_wr", rx_wr_en, 1'b0);
        steps(2);
        reset = 1'b0;
        wait_frames(f0 + 1, 300, "t5");
        step();
        chk("t5_last", last_rx, 8'h22);
        chk("t5_rx_count", rxq.size(), 1);
        rx_pop(v);
        chk("t5_rx", v, 8'h22);

        // TX empty with enable high
        n0 = nrd;
        steps(100);
        chk("t6_no_pop", nrd, n0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_cs_n", cs_n, 1'b1);

        // randomized traffic against a random slave byte stream
        loop = 1'b0;
        f0 = frames_done;
        pushed = 0;
        for (int k = 0; k < 4000; k++) begin
            if (txq.size() < DEPTH && $urandom_range(39) == 0) begin
                tx_push(DW'($urandom));
                pushed++;
            end
            if (rxq.size() > 0 && $urandom_range(59) == 0) rx_pop(v);
            if ($urandom_range(149) == 0) enable = ~enable;
            step();
        end
        enable = 1'b1;
        i = 0;
        while ((txq.size() > 0 || busy) && i < 5000) begin
            if (rxq.size() > 0) rx_pop(v);
            step();
            i++;
        end
        chk("t7_drained", txq.size() == 0 && !busy, 1'b1);
        chk("t7_frames", frames_done - f0, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
